// File: rtl/mouse_packet_decoder_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder:
// FSM states, header bit positions and the overflow saturation magnitude.
package mouse_packet_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  localparam int HDR_LEFT  = 0;
  localparam int HDR_SYNC  = 3;
  localparam int HDR_XSIGN = 4;
  localparam int HDR_YSIGN = 5;
  localparam int HDR_XOVF  = 6;
  localparam int HDR_YOVF  = 7;

  localparam logic [8:0] SAT_MAG = 9'd255;

endpackage

// File: rtl/mouse_axis_decode.sv
// Combinational decode of one mouse axis: 9-bit two's-complement movement
// to a shifted magnitude plus a direction bit that is cleared on zero motion.
module mouse_axis_decode
  import mouse_packet_decoder_pkg::*;
#(
  parameter int SHIFT      = 0,
  parameter bit INVERT_DIR = 1'b0
) (
  input  logic       sign,
  input  logic       overflow,
  input  logic [7:0] data,
  output logic [8:0] magnitude,
  output logic       direction
);

  logic [8:0] w_value;
  logic [8:0] w_abs;
  logic [8:0] w_sat;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    w_value   = {sign, data};
    // -256 negates to 9'h100, which still fits the 9-bit magnitude.
    w_abs     = sign ? (~w_value + 9'd1) : w_value;
    w_sat     = overflow ? SAT_MAG : w_abs;
    magnitude = w_sat >> SHIFT;
    direction = (magnitude != 9'd0) && (sign ^ INVERT_DIR);
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets, drops stalled partial packets after
// an inter-byte timeout, and presents registered speed/direction outputs.
module mouse_packet_decoder
  import mouse_packet_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SPEED_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [9:0] vx,
  output logic [8:0] vy,
  output logic       dx,
  output logic       dy,
  output logic       mousepush,
  output logic       mouseReady
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           r_state;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_hdr;
  logic [7:0]       r_x;

  logic             w_timeout;
  state_t           w_state_eff;
  logic [8:0]       w_x_mag;
  logic [8:0]       w_y_mag;
  logic             w_x_dir;
  logic             w_y_dir;

  // A timeout pulls the FSM back to WAIT_B0 in the same cycle, so a byte
  // arriving then is judged as a fresh header candidate.
  assign w_timeout   = (r_state != WAIT_B0) && (r_gap == GAP_W'(TIMEOUT_CYCLES));
  assign w_state_eff = w_timeout ? WAIT_B0 : r_state;

  mouse_axis_decode #(
    .SHIFT      (SPEED_SHIFT),
    .INVERT_DIR (1'b0)
  ) u_x_decode (
    .sign      (r_hdr[HDR_XSIGN]),
    .overflow  (r_hdr[HDR_XOVF]),
    .data      (r_x),
    .magnitude (w_x_mag),
    .direction (w_x_dir)
  );

  // Y data is taken straight from the bus: it is the byte completing the packet.
  mouse_axis_decode #(
    .SHIFT      (SPEED_SHIFT),
    .INVERT_DIR (1'b1)
  ) u_y_decode (
    .sign      (r_hdr[HDR_YSIGN]),
    .overflow  (r_hdr[HDR_YOVF]),
    .data      (byte_data),
    .magnitude (w_y_mag),
    .direction (w_y_dir)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WAIT_B0;
      r_gap      <= '0;
      r_hdr      <= '0;
      r_x        <= '0;
      vx         <= '0;
      vy         <= '0;
      dx         <= 1'b0;
      dy         <= 1'b0;
      mousepush  <= 1'b0;
      mouseReady <= 1'b0;
    end else begin
      mouseReady <= 1'b0;
      if (byte_valid) begin
        r_gap <= '0;
        case (w_state_eff)
          WAIT_B0: begin
            if (byte_data[HDR_SYNC]) begin
              r_hdr   <= byte_data;
              r_state <= WAIT_B1;
            end else begin
              r_state <= WAIT_B0;
            end
          end
          WAIT_B1: begin
            r_x     <= byte_data;
            r_state <= WAIT_B2;
          end
          WAIT_B2: begin
            vx         <= {1'b0, w_x_mag};
            vy         <= w_y_mag;
            dx         <= w_x_dir;
            dy         <= w_y_dir;
            mousepush  <= r_hdr[HDR_LEFT];
            mouseReady <= 1'b1;
            r_state    <= WAIT_B0;
          end
          default: r_state <= WAIT_B0;
        endcase
      end else if (w_state_eff == WAIT_B0) begin
        r_state <= WAIT_B0;
        r_gap   <= '0;
      end else begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Self-checking bench: two decoders (shift 0 and shift 2) against a
// packet-level reference model, with directed and randomized byte streams.
module tb_mouse_packet_decoder;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic [9:0] vx_a, vx_b;
  logic [8:0] vy_a, vy_b;
  logic       dx_a, dx_b, dy_a, dy_b, push_a, push_b, rdy_a, rdy_b;

  always #5 clk = ~clk;

  mouse_packet_decoder #(.TIMEOUT_CYCLES(T), .SPEED_SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .vx(vx_a), .vy(vy_a), .dx(dx_a), .dy(dy_a),
    .mousepush(push_a), .mouseReady(rdy_a)
  );

  mouse_packet_decoder #(.TIMEOUT_CYCLES(T), .SPEED_SHIFT(2)) u_dut_b (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .vx(vx_b), .vy(vy_b), .dx(dx_b), .dy(dy_b),
    .mousepush(push_b), .mouseReady(rdy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: bytes of the partial packet and cycles since last accepted byte.
  logic [7:0]  pkt[$];
  int          since = 0;
  logic [21:0] exp_a = '0;
  logic [21:0] exp_b = '0;
  logic        exp_rdy = 1'b0;
  int          model_pulses = 0;
  int          obs_pulses = 0;

  function automatic logic [21:0] ref_decode(input logic [7:0] h, input logic [7:0] x,
                                             input logic [7:0] y, input int sh);
    int xm, ym;
    logic ddx, ddy;
    xm = h[4] ? 256 - int'(x) : int'(x);
    ym = h[5] ? 256 - int'(y) : int'(y);
    if (h[6]) xm = 255;
    if (h[7]) ym = 255;
    xm  = xm >> sh;
    ym  = ym >> sh;
    ddx = h[4] && (xm != 0);
    ddy = !h[5] && (ym != 0);
    return {10'(xm), 9'(ym), ddx, ddy, h[0]};
  endfunction

  function automatic void model_step(input logic r, input logic v, input logic [7:0] d);
    exp_rdy = 1'b0;
    if (r) begin
      pkt.delete();
      since = 0;
      exp_a = '0;
      exp_b = '0;
      return;
    end
    since++;
    if (pkt.size() != 0 && since > T) pkt.delete();
    if (v) begin
      if (pkt.size() != 0 || d[3]) pkt.push_back(d);
      since = 0;
      if (pkt.size() == 3) begin
        exp_a   = ref_decode(pkt[0], pkt[1], pkt[2], 0);
        exp_b   = ref_decode(pkt[0], pkt[1], pkt[2], 2);
        exp_rdy = 1'b1;
        model_pulses++;
        pkt.delete();
      end
    end
  endfunction

  function automatic logic [45:0] observed();
    return {vx_a, vy_a, dx_a, dy_a, push_a, rdy_a, vx_b, vy_b, dx_b, dy_b, push_b, rdy_b};
  endfunction

  function automatic logic [45:0] expected();
    return {exp_a, exp_rdy, exp_b, exp_rdy};
  endfunction

  // One clock: drive inputs, let the edge pass, advance the model, settle.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    rst        = r;
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    cyc++;
    if (rdy_a === 1'b1) obs_pulses++;
    rst        = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      n_checks++;
      if (observed() !== 46'd0) $display("FAIL reset cycle %0d: got %h expected 0", cyc, observed());
      else n_pass++;
    end
  endtask

  // Spec packets sent back-to-back, each checked by the model and literal values.
  task automatic test_directed();
    logic [7:0]  bytes [9];
    logic [21:0] lit   [3];
    bytes = '{8'h08, 8'h05, 8'h03, 8'h39, 8'h00, 8'hFE, 8'h48, 8'h10, 8'h00};
    lit   = '{{10'd5, 9'd3, 1'b0, 1'b1, 1'b0},
              {10'd256, 9'd2, 1'b1, 1'b0, 1'b1},
              {10'd255, 9'd0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, bytes[i]);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL directed byte %0d: got %h expected %h", i, observed(), expected());
      else n_pass++;
      if (i % 3 == 2) begin
        n_checks++;
        if ({vx_a, vy_a, dx_a, dy_a, push_a, rdy_a} !== {lit[i/3], 1'b1})
          $display("FAIL directed_literal pkt %0d: got %h expected %h", i / 3,
                   {vx_a, vy_a, dx_a, dy_a, push_a, rdy_a}, {lit[i/3], 1'b1});
        else n_pass++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL directed_hold cycle %0d: got %h expected %h", cyc, observed(), expected());
      else n_pass++;
    end
  endtask

  task automatic test_resync();
    logic [7:0] bytes [4];
    int p0;
    bytes = '{8'h00, 8'h08, 8'h01, 8'h01};
    p0 = obs_pulses;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, bytes[i]);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL resync byte %0d: got %h expected %h", i, observed(), expected());
      else n_pass++;
      cycle(1'b0, 1'b0, 8'h00);
    end
    n_checks++;
    if (obs_pulses - p0 != 1 || vx_a !== 10'd1 || vy_a !== 9'd1)
      $display("FAIL resync_pulses: got pulses=%0d vx=%0d vy=%0d expected 1/1/1",
               obs_pulses - p0, vx_a, vy_a);
    else n_pass++;
  endtask

  // Gaps around the timeout boundary, including a byte landing on the timeout cycle.
  task automatic test_timeout();
    int gaps [3];
    int p0;
    gaps = '{T + 1, T - 1, T};
    for (int g = 0; g < 3; g++) begin
      p0 = obs_pulses;
      cycle(1'b0, 1'b1, 8'h08);
      cycle(1'b0, 1'b1, 8'h05);
      for (int k = 0; k < gaps[g]; k++) begin
        cycle(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (observed() !== expected())
          $display("FAIL timeout_gap g=%0d k=%0d: got %h expected %h", g, k, observed(), expected());
        else n_pass++;
      end
      cycle(1'b0, 1'b1, 8'h09);
      cycle(1'b0, 1'b1, 8'h02);
      cycle(1'b0, 1'b1, 8'h02);
      n_checks++;
      if (observed() !== expected())
        $display("FAIL timeout_end g=%0d: got %h expected %h", g, observed(), expected());
      else n_pass++;
      cycle(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (obs_pulses - p0 != 1 || (g == 0 && vx_a !== 10'd2))
        $display("FAIL timeout_pulses g=%0d: got pulses=%0d vx=%0d expected 1", g,
                 obs_pulses - p0, vx_a);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [4];
    int p0;
    bytes = '{8'h07, 8'h01, 8'h02, 8'h03};
    cycle(1'b1, 1'b0, 8'h00);
    p0 = obs_pulses;
    cycle(1'b0, 1'b1, 8'h08);
    cycle(1'b0, 1'b1, 8'h05);
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, bytes[i]);
      n_checks++;
      if (observed() !== 46'd0 || observed() !== expected())
        $display("FAIL reset_mid byte %0d: got %h expected 0", i, observed());
      else n_pass++;
    end
    n_checks++;
    if (obs_pulses != p0) $display("FAIL reset_mid_pulses: got %0d expected 0", obs_pulses - p0);
    else n_pass++;
  endtask

  task automatic test_random();
    int burst, nbytes, m0, p0;
    logic [7:0] d;
    m0 = model_pulses;
    p0 = obs_pulses;
    for (int i = 0; i < 150; i++) begin
      burst  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 2, T + 3)) : int'($urandom_range(0, 2));
      nbytes = $urandom_range(1, 6);
      for (int k = 0; k < burst + nbytes; k++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 2) == 0) d[3] = 1'b1;
        cycle(($urandom_range(0, 299) == 0), (k >= burst), d);
        n_checks++;
        if (observed() !== expected())
          $display("FAIL random cycle %0d: got %h expected %h", cyc, observed(), expected());
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_pulses - p0 != model_pulses - m0)
      $display("FAIL random_pulses: got %0d expected %0d", obs_pulses - p0, model_pulses - m0);
    else n_pass++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_resync();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mouse_packet_decoder.md
MOUSE_PACKET_DECODER -- requirements
Module: mouse_packet_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, SHALL set the maximum inter-byte gap in clk cycles (20 ms at 100 MHz) before a partial packet is discarded.
REQ-002 Parameter SPEED_SHIFT, default 0, SHALL set the right-shift applied to decoded magnitudes.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is rising-edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 byte_valid  input  1  SHALL be a one-cycle strobe from the PS/2 receiver marking a valid byte_data.
REQ-006 byte_data  input  8  SHALL be the received PS/2 mouse byte.
REQ-007 vx  output  10  SHALL be the X speed magnitude.
REQ-008 vy  output  9  SHALL be the Y speed magnitude.
REQ-009 dx  output  1  SHALL be the X direction: 1 = decreasing screen x.
REQ-010 dy  output  1  SHALL be the Y direction: 1 = decreasing screen y (mouse moved up).
REQ-011 mousepush  output  1  SHALL be the left-button state.
REQ-012 mouseReady  output  1  SHALL be a one-cycle pulse marking a new packet on the outputs.

Function
REQ-013 The FSM SHALL have the states WAIT_B0, WAIT_B1 and WAIT_B2.
REQ-014 In WAIT_B0, a byte with bit3=1 SHALL be latched as the header and move the FSM to WAIT_B1; a byte with bit3=0 SHALL be discarded and the FSM SHALL stay in WAIT_B0.
REQ-015 In WAIT_B1, a byte SHALL be latched as X data and move the FSM to WAIT_B2.
REQ-016 In WAIT_B2, a byte SHALL complete the packet and return the FSM to WAIT_B0.
REQ-017 Header fields SHALL be: bit0 left, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-018 Each axis SHALL be decoded as the 9-bit two's-complement value {sign, data}, giving magnitude = |value| in the range 0..256.
REQ-019 When an axis overflow bit is set, that axis magnitude SHALL saturate to 255, with the sign bit still defining direction.
REQ-020 Each magnitude SHALL be shifted right by SPEED_SHIFT, then zero-extended to 10 bits for vx and kept at 9 bits for vy.
REQ-021 dx SHALL equal the X sign, and dy SHALL equal the inverted Y sign; either direction bit SHALL be forced to 0 when its final magnitude is 0.
REQ-022 mousepush SHALL equal header bit0.
REQ-023 If the third byte is accepted in cycle N, vx, vy, dx, dy and mousepush SHALL update at N+1, and mouseReady SHALL be high for exactly cycle N+1.
REQ-024 Outputs SHALL hold their values between packets.
REQ-025 The gap counter SHALL clear on every accepted byte and count while the FSM is in WAIT_B1 or WAIT_B2.
REQ-026 When the gap counter reaches TIMEOUT_CYCLES, the FSM SHALL return to WAIT_B0, the partial packet SHALL be dropped and no pulse SHALL be generated.
REQ-027 If a timeout and byte_valid occur in the same cycle, the timeout SHALL win and that byte SHALL be evaluated as a WAIT_B0 header candidate in the same cycle.
REQ-028 byte_valid SHALL be accepted back-to-back, one byte per cycle, with no stall.

Reset
REQ-029 While rst=1 the FSM SHALL be in WAIT_B0, the gap counter and latched bytes SHALL be 0, and vx, vy, dx, dy, mousepush and mouseReady SHALL all be 0.
REQ-030 A reset asserted mid-packet SHALL discard the partial packet; the first byte after reset SHALL be treated as a header candidate.

Structure
REQ-031 A shared package SHALL hold the state enum, the header bit-position constants, and the saturation value 255.
REQ-032 One combinational sub-module, mouse_axis_decode (inputs sign, overflow, data; outputs magnitude and direction), SHALL be instantiated once per axis.

Verification
REQ-033 Bytes 0x08, 0x05, 0x03 -> vx=5, dx=0, vy=3, dy=1, mousepush=0, with mouseReady for one cycle one clk after the third byte.
REQ-034 Bytes 0x39, 0x00, 0xFE -> vx=256, dx=1, vy=2, dy=0, mousepush=1.
REQ-035 Bytes 0x48, 0x10, 0x00 -> vx=255, dx=0, vy=0, dy=0.
REQ-036 Byte 0x00, then the valid packet 0x08, 0x01, 0x01 -> the first byte is discarded and exactly one mouseReady pulse occurs, with vx=1 and vy=1.
REQ-037 Bytes 0x08, 0x05, a gap of TIMEOUT_CYCLES, then 0x08, 0x02, 0x02 -> no pulse for the broken packet, then one pulse with vx=2 and vy=2.
REQ-038 rst pulsed between bytes 2 and 3 of a packet -> outputs stay 0, and the following byte 0x07 is discarded.
